// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect/stall control in, PC out, instruction back, IF/ID register out.
interface fetch_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   jump;
    logic [PC_WIDTH-1:0]    jump_target;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [PC_WIDTH-1:0]    if_id_pc;
    logic [PC_WIDTH-1:0]    if_id_pc_plus1;
    logic                   if_id_valid;
    logic                   halted;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, instr_in,
        output pc, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, halted
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, instr_in,
        input  pc, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, handles stall,
// branch/jump redirects and a halt opcode that freezes fetch until reset.
module fetch_unit #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
    parameter logic [3:0]             HALT_OPCODE = 4'b1111,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {START, RUN, HALTED} state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    state_t                 state_p0;
    logic [PC_WIDTH-1:0]    pc_p0;
    logic                   halted_p0;
    logic [INSTR_WIDTH-1:0] instr_p1;
    logic [PC_WIDTH-1:0]    pc_p1;
    logic [PC_WIDTH-1:0]    pc_plus1_p1;
    logic                   vld_p1;

    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   is_halt;

    // Word-addressed sequential step, wrapping modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] a);
        return a + PC_ONE;
    endfunction

    always_comb begin
        redirect    = bus.jump | bus.branch_taken;
        redirect_pc = bus.jump ? bus.jump_target : bus.branch_target;
        is_halt     = (bus.instr_in[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    end

    // p0 -> p1: PC/state update and IF/ID capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0    <= START;
            pc_p0       <= RESET_PC;
            halted_p0   <= 1'b0;
            instr_p1    <= NOP_INSTR;
            pc_p1       <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            case (state_p0)
                START: begin
                    vld_p1   <= 1'b0;
                    state_p0 <= RUN;
                end
                RUN: begin
                    // A redirect flushes even under stall and suppresses a fetched halt.
                    if (redirect) begin
                        pc_p0    <= redirect_pc;
                        instr_p1 <= NOP_INSTR;
                        vld_p1   <= 1'b0;
                    end else if (!bus.stall) begin
                        instr_p1    <= bus.instr_in;
                        pc_p1       <= pc_p0;
                        pc_plus1_p1 <= pc_inc(pc_p0);
                        vld_p1      <= 1'b1;
                        pc_p0       <= pc_inc(pc_p0);
                        if (is_halt) begin
                            state_p0  <= HALTED;
                            halted_p0 <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (!bus.stall) begin
                        instr_p1 <= NOP_INSTR;
                        vld_p1   <= 1'b0;
                    end
                end
                default: state_p0 <= START;
            endcase
        end
    end

    assign bus.pc             = pc_p0;
    assign bus.halted         = halted_p0;
    assign bus.if_id_instr    = instr_p1;
    assign bus.if_id_pc       = pc_p1;
    assign bus.if_id_pc_plus1 = pc_plus1_p1;
    assign bus.if_id_valid    = vld_p1;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stimulus against a behavioural model.
module tb_fetch_unit;
    logic clk;
    logic reset;
    logic [15:0] mem [0:15];

    fetch_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus ();

    fetch_unit #(
        .PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000),
        .HALT_OPCODE(4'b1111), .NOP_INSTR(16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instr_in = mem[bus.pc[3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch pointer, latched word, and two lifecycle flags.
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
    logic        m_valid, m_started, m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc1 = 16'h0000;
        m_valid = 1'b0; m_started = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] w;
        if (!m_started) begin
            m_valid = 1'b0;
            m_started = 1'b1;
        end else if (m_halted) begin
            if (!bus.stall) begin
                m_valid = 1'b0;
                m_instr = 16'h0000;
            end
        end else if (bus.jump || bus.branch_taken) begin
            m_pc    = bus.jump ? bus.jump_target : bus.branch_target;
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end else if (!bus.stall) begin
            w       = mem[m_pc[3:0]];
            m_instr = w;
            m_ipc   = m_pc;
            m_ipc1  = m_pc + 16'd1;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
        end
    endtask

    task automatic check_all();
        check("pc",             32'(bus.pc),             32'(m_pc));
        check("if_id_instr",    32'(bus.if_id_instr),    32'(m_instr));
        check("if_id_pc",       32'(bus.if_id_pc),       32'(m_ipc));
        check("if_id_pc_plus1", 32'(bus.if_id_pc_plus1), 32'(m_ipc1));
        check("if_id_valid",    32'(bus.if_id_valid),    32'(m_valid));
        check("halted",         32'(bus.halted),         32'(m_halted));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // Reset is raised between edges so its effect must be visible before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_ctrl();
        bus.stall = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
        bus.jump_target = 16'h0000; bus.branch_target = 16'h0000;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    endtask

    initial begin
        reset = 1'b1;
        clear_ctrl();
        fill_mem();
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Free run: START holds pc=0 for one edge.
        step(5);
        check("run_pc", 32'(bus.pc), 32'h4);
        check("run_instr", 32'(bus.if_id_instr), 32'h1003);

        bus.stall = 1'b1;
        step(3);
        check("stall_pc", 32'(bus.pc), 32'h4);
        check("stall_ipc1", 32'(bus.if_id_pc_plus1), 32'h4);
        bus.stall = 1'b0;
        step(1);
        check("resume_instr", 32'(bus.if_id_instr), 32'h1004);
        step(1);

        bus.branch_taken = 1'b1; bus.branch_target = 16'h000A;
        step(1);
        check("br_pc", 32'(bus.pc), 32'hA);
        check("br_valid", 32'(bus.if_id_valid), 32'h0);
        clear_ctrl();
        step(1);
        check("br_instr", 32'(bus.if_id_instr), 32'h100A);

        bus.jump = 1'b1; bus.jump_target = 16'h0002;
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0009; bus.stall = 1'b1;
        step(1);
        check("jmp_pc", 32'(bus.pc), 32'h2);
        clear_ctrl();

        mem[5] = 16'hF000;
        step(4);
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_instr", 32'(bus.if_id_instr), 32'hF000);
        check("halt_pc", 32'(bus.pc), 32'h6);
        step(1);
        bus.jump = 1'b1; bus.jump_target = 16'h0000;
        step(2);
        check("halt_hold_pc", 32'(bus.pc), 32'h6);
        clear_ctrl();
        do_reset();
        mem[5] = 16'h1005;

        step(1);
        bus.jump = 1'b1; bus.jump_target = 16'hFFFF;
        step(1);
        clear_ctrl();
        step(1);
        check("wrap_pc", 32'(bus.pc), 32'h0);
        check("wrap_ipc1", 32'(bus.if_id_pc_plus1), 32'h0);
        step(2);
        do_reset();

        // Random phase.
        for (int c = 0; c < 600; c++) begin
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.jump          = ($urandom_range(0, 9) == 0);
            bus.branch_taken  = ($urandom_range(0, 7) == 0);
            bus.jump_target   = 16'($urandom);
            bus.branch_target = 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, 15)] = ($urandom_range(0, 24) == 0) ?
                    {4'hF, 12'($urandom)} : {4'($urandom_range(0, 14)), 12'($urandom)};
            if ($urandom_range(0, 29) == 0 || (m_halted && $urandom_range(0, 5) == 0))
                do_reset();
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
